// File: rtl/debug_input_conditioner.sv
// ---------------------------------------------------------------------------
// debug_input_conditioner
//
// Front end for the board debug viewer. It synchronizes and debounces the raw
// pushbuttons and slide switches, generates one-cycle press/step pulses, and
// holds the view-mode and address-pointer state that the viewer consumes.
//
// Parameters:
//   DEBOUNCE_CYCLES : consecutive stable synced cycles before a clean output
//                     changes (>= 2)
//   CNT_W           : debounce counter width, must hold DEBOUNCE_CYCLES-1
//
// Ports:
//   Clock      in   1   system clock
//   Resetn     in   1   asynchronous active-low reset
//   KEY_raw    in   4   raw pushbuttons, active-low (1 = released)
//   SW_raw     in  17   raw slide switches
//   KEY_clean  out  4   debounced KEY, active-low
//   key_press  out  4   one-cycle pulse per debounced press (1->0 of KEY_clean)
//   SW_clean   out 17   debounced switches
//   step_pulse out  1   one-cycle pulse on debounced 0->1 of SW_clean[16]
//   mem_mode   out  2   view select: 00 MEM, 01 REG, 10 PSW
//   addr       out 16   viewer address / register pointer
// ---------------------------------------------------------------------------
module debug_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic [3:0]  KEY_raw,
    input  logic [16:0] SW_raw,
    output logic [3:0]  KEY_clean,
    output logic [3:0]  key_press,
    output logic [16:0] SW_clean,
    output logic        step_pulse,
    output logic [1:0]  mem_mode,
    output logic [15:0] addr
);

    // All 21 inputs are handled as one vector: bits [3:0] are KEY, [20:4] SW.
    localparam int unsigned        NBITS    = 21;
    localparam logic [NBITS-1:0]   RST_VEC  = {17'b0, 4'hF};
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        MODE_MEM = 2'b00,
        MODE_REG = 2'b01,
        MODE_PSW = 2'b10
    } mode_t;

    logic [NBITS-1:0] w_raw;
    logic [NBITS-1:0] r_sync1;
    logic [NBITS-1:0] r_sync2;
    logic [NBITS-1:0] r_clean;
    logic [NBITS-1:0] r_clean_d;
    logic [CNT_W-1:0] r_cnt [NBITS];

    logic [3:0]       w_key_press;
    logic             w_step_pulse;
    logic             w_sw_load;
    logic [3:0]       r_key_press;
    logic             r_step_pulse;

    mode_t            r_mode;
    mode_t            w_mode_next;
    logic [15:0]      r_addr;
    logic [15:0]      w_addr_next;

    assign w_raw = {SW_raw, KEY_raw};

    // -----------------------------------------------------------------------
    // Two-flop synchronizer
    // -----------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_sync1 <= RST_VEC;
            r_sync2 <= RST_VEC;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // -----------------------------------------------------------------------
    // Per-bit debounce: the counter only advances while the synced value
    // disagrees with the clean value, so any bounce back restarts it.
    // -----------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_clean   <= RST_VEC;
            r_clean_d <= RST_VEC;
            for (int unsigned i = 0; i < NBITS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_clean_d <= r_clean;
            for (int unsigned i = 0; i < NBITS; i++) begin
                if (r_sync2[i] != r_clean[i]) begin
                    if (r_cnt[i] == CNT_LAST) begin
                        r_clean[i] <= r_sync2[i];
                        r_cnt[i]   <= '0;
                    end else begin
                        r_cnt[i]   <= r_cnt[i] + CNT_W'(1);
                    end
                end else begin
                    r_cnt[i] <= '0;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Edge detection against the previous clean value. The same combinational
    // terms drive the pulse registers and the mode/address updates, so all of
    // them change on the same edge.
    // -----------------------------------------------------------------------
    always_comb begin
        w_key_press  = r_clean_d[3:0] & ~r_clean[3:0];
        w_step_pulse = ~r_clean_d[20] & r_clean[20];
        w_sw_load    = (r_clean_d[19:4] != r_clean[19:4]);
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_key_press  <= '0;
            r_step_pulse <= 1'b0;
        end else begin
            r_key_press  <= w_key_press;
            r_step_pulse <= w_step_pulse;
        end
    end

    // -----------------------------------------------------------------------
    // View-mode state machine
    // -----------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_mode <= MODE_MEM;
        end else begin
            r_mode <= w_mode_next;
        end
    end

    always_comb begin
        w_mode_next = r_mode;
        if (w_key_press[1] && !w_key_press[2]) begin
            case (r_mode)
                MODE_MEM: w_mode_next = MODE_REG;
                MODE_REG: w_mode_next = MODE_PSW;
                default:  w_mode_next = MODE_MEM;
            endcase
        end else if (w_key_press[2] && !w_key_press[1]) begin
            case (r_mode)
                MODE_MEM: w_mode_next = MODE_PSW;
                MODE_PSW: w_mode_next = MODE_REG;
                default:  w_mode_next = MODE_MEM;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Address pointer: a switch change takes priority over a KEY0 increment,
    // and the increment is interpreted in the current (pre-update) mode.
    // -----------------------------------------------------------------------
    always_comb begin
        w_addr_next = r_addr;
        if (w_sw_load) begin
            w_addr_next = r_clean[19:4];
        end else if (w_key_press[0]) begin
            case (r_mode)
                MODE_MEM: w_addr_next = r_addr + 16'd2;
                MODE_REG: w_addr_next = {13'b0, r_addr[2:0] + 3'd1};
                default:  w_addr_next = r_addr;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_addr <= '0;
        end else begin
            r_addr <= w_addr_next;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign KEY_clean  = r_clean[3:0];
    assign SW_clean   = r_clean[20:4];
    assign key_press  = r_key_press;
    assign step_pulse = r_step_pulse;
    assign mem_mode   = r_mode;
    assign addr       = r_addr;

endmodule

// File: tb/tb_debug_input_conditioner.sv
// ---------------------------------------------------------------------------
// tb_debug_input_conditioner
//
// Directed bench for debug_input_conditioner with DEBOUNCE_CYCLES = 4.
// A raw change driven just after an edge is first sampled on the next edge;
// clean follows 6 edges after the drive, the pulse / mode / addr update
// lands on the 7th edge and the pulse clears on the 8th.
// ---------------------------------------------------------------------------
module tb_debug_input_conditioner;

    logic        Clock = 1'b0;
    logic        Resetn = 1'b1;
    logic [3:0]  KEY_raw = 4'hF;
    logic [16:0] SW_raw = '0;
    logic [3:0]  KEY_clean;
    logic [3:0]  key_press;
    logic [16:0] SW_clean;
    logic        step_pulse;
    logic [1:0]  mem_mode;
    logic [15:0] addr;

    int errors = 0;
    int checks = 0;

    debug_input_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .KEY_raw   (KEY_raw),
        .SW_raw    (SW_raw),
        .KEY_clean (KEY_clean),
        .key_press (key_press),
        .SW_clean  (SW_clean),
        .step_pulse(step_pulse),
        .mem_mode  (mem_mode),
        .addr      (addr)
    );

    always #5 Clock = ~Clock;

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Press the keys in mask m together, verify debounce timing and a single
    // pulse, then release and verify that release produces no pulse.
    task automatic press_release(input logic [3:0] m);
        logic [3:0] nm;
        nm = ~m;
        KEY_raw = nm;
        repeat (5) tick;
        chk("key_clean_pre", KEY_clean, 4'hF);
        tick;
        chk("key_clean_fall", KEY_clean, nm);
        chk("press_not_early", key_press, 4'h0);
        tick;
        chk("press_pulse", key_press, m);
        tick;
        chk("press_one_cycle", key_press, 4'h0);
        KEY_raw = 4'hF;
        repeat (8) begin
            tick;
            chk("no_release_pulse", key_press, 4'h0);
        end
        chk("key_clean_release", KEY_clean, 4'hF);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_key_clean"}, KEY_clean, 4'hF);
        chk({tag, "_sw_clean"}, SW_clean, 17'h0);
        chk({tag, "_key_press"}, key_press, 4'h0);
        chk({tag, "_step"}, step_pulse, 1'b0);
        chk({tag, "_mode"}, mem_mode, 2'b00);
        chk({tag, "_addr"}, addr, 16'h0000);
    endtask

    initial begin
        // ---------------- power-on reset ----------------
        #1 Resetn = 1'b0;
        #1;
        chk_reset_outputs("por");
        repeat (2) tick;
        Resetn = 1'b1;
        tick;

        // ---------------- bounce on KEY1 ----------------
        for (int p = 0; p < 6; p++) begin
            KEY_raw[1] = (p % 2 == 1);
            repeat (2) begin
                tick;
                chk("bounce_clean", KEY_clean, 4'hF);
                chk("bounce_press", key_press, 4'h0);
            end
        end
        KEY_raw[1] = 1'b0;
        repeat (5) tick;
        chk("bounce_clean_hold", KEY_clean[1], 1'b1);
        tick;
        chk("bounce_clean_fall", KEY_clean[1], 1'b0);
        tick;
        chk("bounce_press", key_press, 4'h2);
        chk("bounce_mode", mem_mode, 2'b01);
        tick;
        chk("bounce_press_end", key_press, 4'h0);
        KEY_raw = 4'hF;
        repeat (8) tick;

        // ---------------- mode wrap ----------------
        press_release(4'b0010);
        chk("mode_to_psw", mem_mode, 2'b10);
        press_release(4'b0010);
        chk("mode_to_mem", mem_mode, 2'b00);
        press_release(4'b0010);
        chk("wrap_1", mem_mode, 2'b01);
        press_release(4'b0010);
        chk("wrap_2", mem_mode, 2'b10);
        press_release(4'b0010);
        chk("wrap_3", mem_mode, 2'b00);
        press_release(4'b0100);
        chk("prev_from_mem", mem_mode, 2'b10);
        press_release(4'b0110);
        chk("both_no_change", mem_mode, 2'b10);

        // ---------------- address pointer ----------------
        SW_raw[15:0] = 16'hFFFE;
        repeat (8) tick;
        chk("sw_load", addr, 16'hFFFE);
        press_release(4'b0001);
        chk("psw_no_inc", addr, 16'hFFFE);
        press_release(4'b0010);
        chk("to_mem", mem_mode, 2'b00);
        press_release(4'b0001);
        chk("mem_wrap", addr, 16'h0000);
        press_release(4'b0010);
        chk("to_reg", mem_mode, 2'b01);
        SW_raw[15:0] = 16'h1235;
        repeat (8) tick;
        chk("sw_load2", addr, 16'h1235);
        press_release(4'b0001);
        chk("reg_inc1", addr, 16'h0006);
        press_release(4'b0001);
        chk("reg_inc2", addr, 16'h0007);
        press_release(4'b0001);
        chk("reg_inc3", addr, 16'h0000);
        SW_raw[15:0] = 16'h0100;
        press_release(4'b0001);
        chk("sw_beats_inc", addr, 16'h0100);
        press_release(4'b0011);
        chk("inc_old_mode", addr, 16'h0001);
        chk("mode_with_inc", mem_mode, 2'b10);

        // ---------------- step pulse ----------------
        SW_raw[16] = 1'b1;
        repeat (6) tick;
        chk("step_clean", SW_clean[16], 1'b1);
        chk("step_not_early", step_pulse, 1'b0);
        tick;
        chk("step_pulse", step_pulse, 1'b1);
        tick;
        chk("step_one_cycle", step_pulse, 1'b0);
        chk("step_addr_kept", addr, 16'h0001);
        SW_raw[16] = 1'b0;
        repeat (8) begin
            tick;
            chk("step_fall_none", step_pulse, 1'b0);
        end
        chk("step_clean_low", SW_clean[16], 1'b0);
        SW_raw[16] = 1'b1;
        repeat (3) begin
            tick;
            chk("glitch_none", step_pulse, 1'b0);
        end
        SW_raw[16] = 1'b0;
        repeat (8) begin
            tick;
            chk("glitch_none", step_pulse, 1'b0);
            chk("glitch_clean", SW_clean[16], 1'b0);
        end

        // ---------------- asynchronous reset mid-run ----------------
        chk("pre_reset_sw", SW_clean, 17'h00100);
        SW_raw = '0;
        #3 Resetn = 1'b0;
        #1;
        chk_reset_outputs("async");
        tick;
        Resetn = 1'b1;
        tick;

        // ---------------- reset mid-debounce ----------------
        KEY_raw[0] = 1'b0;
        repeat (3) tick;
        Resetn = 1'b0;
        #1;
        chk("mid_rst_clean", KEY_clean, 4'hF);
        tick;
        Resetn = 1'b1;
        repeat (5) begin
            tick;
            chk("mid_rst_hold", KEY_clean[0], 1'b1);
            chk("mid_rst_nopress", key_press, 4'h0);
        end
        tick;
        chk("mid_rst_fall", KEY_clean[0], 1'b0);
        chk("mid_rst_not_early", key_press, 4'h0);
        tick;
        chk("mid_rst_press", key_press, 4'h1);
        chk("mid_rst_mode", mem_mode, 2'b00);
        chk("mid_rst_addr", addr, 16'h0002);
        tick;
        chk("mid_rst_press_end", key_press, 4'h0);
        KEY_raw = 4'hF;
        repeat (8) tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
